// File: rtl/synth_channel_mixer.sv
// rtl/synth_channel_mixer.sv - per-slot gain, frame accumulation and saturating mono output
//
// Scales each time-multiplexed channel slot by its envelope (Q8) and volume (Q7).
// Sums all slots of a frame and saturates the total to one signed sample.
// Presents that sample through a single valid/ready output register.
// Optional build macro MIXER_SOFT_CLIP_EN: a soft knee replaces the hard
// saturation and adds one register stage (latency 3 instead of 2).
//
// Ports:
//   clock        system clock, posedge
//   reset_n      synchronous active-low reset
//   in_valid     slot valid (never back-pressured)
//   in_channel   slot index, selects mute_mask bit
//   in_last      final slot of the frame
//   in_sample    signed oscillator sample
//   in_envelope  envelope amplitude, Q8
//   in_volume    channel volume, Q7
//   mute_mask    per-channel mute, 1 = contributes 0
//   out_valid    out_sample holds an unconsumed frame
//   out_ready    consumer accepts when out_valid && out_ready
//   out_sample   mixed frame sample
//   drop_count   frames discarded on a full output register, saturating
module synth_channel_mixer #(
  parameter int NUM_CHANNELS = 16,
  parameter int SAMPLE_W     = 16,
  parameter int ACC_W        = 24,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [CH_W-1:0]            in_channel,
  input  logic                       in_last,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic [7:0]                 in_envelope,
  input  logic [6:0]                 in_volume,
  input  logic [NUM_CHANNELS-1:0]    mute_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [7:0]                 drop_count
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  // Stage 1: envelope gain and mute
  logic                       mute_hit;
  logic signed [SAMPLE_W+8:0] prod1;
  logic signed [SAMPLE_W-1:0] p1_c;

  // Indices beyond NUM_CHANNELS never match, so they stay unmuted.
  always_comb begin
    mute_hit = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (in_channel == CH_W'(i)) mute_hit = mute_mask[i];
    end
  end

  // Envelope is unsigned; a zero-extended signed operand keeps the multiply signed.
  // >>> on the signed product floors toward minus infinity.
  assign prod1 = in_sample * $signed({1'b0, in_envelope});
  assign p1_c  = mute_hit ? '0 : SAMPLE_W'(prod1 >>> 8);

  logic                       s1_valid;
  logic                       s1_last;
  logic signed [SAMPLE_W-1:0] s1_p1;
  logic [6:0]                 s1_volume;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_p1     <= '0;
      s1_volume <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && in_last;
      if (in_valid) begin
        s1_p1     <= p1_c;
        s1_volume <= in_volume;
      end
    end
  end

  // Stage 2: volume gain and frame accumulation
  logic signed [SAMPLE_W+7:0] prod2;
  logic signed [SAMPLE_W-1:0] p2_c;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum_c;

  assign prod2 = s1_p1 * $signed({1'b0, s1_volume});
  assign p2_c  = SAMPLE_W'(prod2 >>> 7);
  assign sum_c = acc + {{(ACC_W - SAMPLE_W){p2_c[SAMPLE_W-1]}}, p2_c};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (s1_valid) begin
      acc <= s1_last ? '0 : sum_c;
    end
  end

  // Frame result: res_valid pulses for one cycle with the limited frame sum
  logic                       res_valid;
  logic signed [SAMPLE_W-1:0] res_sample;

`ifdef MIXER_SOFT_CLIP_EN
  localparam logic [ACC_W-1:0] KNEE  = ACC_W'(1) << (SAMPLE_W - 2);
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);

  logic [ACC_W-1:0]           mag;
  logic [ACC_W-1:0]           knee_y;
  logic signed [SAMPLE_W-1:0] clip_c;

  // Compress magnitude above the knee by 4:1; symmetric cap keeps +/- limits equal.
  always_comb begin
    mag    = sum_c[ACC_W-1] ? ACC_W'(-sum_c) : ACC_W'(sum_c);
    knee_y = (mag <= KNEE) ? mag : KNEE + ((mag - KNEE) >> 2);
    if (knee_y > MAG_MAX) knee_y = MAG_MAX;
    clip_c = sum_c[ACC_W-1] ? -SAMPLE_W'(knee_y) : SAMPLE_W'(knee_y);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_sample <= '0;
    end else begin
      res_valid  <= s1_valid && s1_last;
      res_sample <= clip_c;
    end
  end
`else
  logic signed [SAMPLE_W-1:0] sat_c;

  always_comb begin
    if (sum_c > SAT_MAX)      sat_c = SAMPLE_W'(SAT_MAX);
    else if (sum_c < SAT_MIN) sat_c = SAMPLE_W'(SAT_MIN);
    else                      sat_c = SAMPLE_W'(sum_c);
  end

  assign res_valid  = s1_valid && s1_last;
  assign res_sample = sat_c;
`endif

  // Output register: a held, unconsumed sample wins over a new result.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      drop_count <= '0;
    end else if (res_valid) begin
      if (!out_valid || out_ready) begin
        out_valid  <= 1'b1;
        out_sample <= res_sample;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_synth_channel_mixer.sv
// tb/tb_synth_channel_mixer.sv - scoreboard bench for synth_channel_mixer
module tb_synth_channel_mixer;

  localparam int NCH = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [3:0]        in_channel;
  logic              in_last;
  logic signed [15:0] in_sample;
  logic [7:0]        in_envelope;
  logic [6:0]        in_volume;
  logic [NCH-1:0]    mute_mask;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_sample;
  logic [7:0]        drop_count;

  synth_channel_mixer #(.NUM_CHANNELS(NCH), .SAMPLE_W(16), .ACC_W(24)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_channel (in_channel),
    .in_last    (in_last),
    .in_sample  (in_sample),
    .in_envelope(in_envelope),
    .in_volume  (in_volume),
    .mute_mask  (mute_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_m    = 0;
  bit sb_enable = 1'b1;
  int sb[$];
  int pop_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drives one slot for one clock and updates the reference model.
  task automatic drive_slot(input int ch, input int smp, input int env, input int vol, input bit last);
    int p1;
    int p2;
    in_valid    = 1'b1;
    in_channel  = 4'(ch);
    in_last     = last;
    in_sample   = 16'(smp);
    in_envelope = 8'(env);
    in_volume   = 7'(vol);
    p1 = (smp * env) >>> 8;
    if (mute_mask[ch]) p1 = 0;
    p2 = (p1 * vol) >>> 7;
    acc_m += p2;
    if (last) begin
      if (acc_m > 32767) acc_m = 32767;
      if (acc_m < -32768) acc_m = -32768;
      if (sb_enable) sb.push_back(acc_m);
      acc_m = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Consumer monitor: each accepted output must match the oldest expected frame.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) check("unexpected_out", 32'(out_sample), 99999);
      else check("out_sample", 32'(out_sample), sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] r;
    reset_n = 1'b0; in_valid = 1'b0; in_channel = '0; in_last = 1'b0;
    in_sample = '0; in_envelope = '0; in_volume = '0; mute_mask = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sample", 32'(out_sample), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    reset_n = 1'b1;
    idle(1);

    // T1: 4 x 8128 = 32512, latency check
    for (int c = 0; c < 4; c++) drive_slot(c, 16384, 128, 127, c == 3);
    in_valid = 1'b0; in_last = 1'b0;
    check("t1_valid_e0", 32'(out_valid), 0);
    @(posedge clock); #1;
    check("t1_valid_e1", 32'(out_valid), 1);
    drain();

    // T2: hard saturation
    for (int c = 0; c < 4; c++) drive_slot(c, 16384, 255, 127, c == 3);
    drain();

    // T3: negative full scale, then muted
    drive_slot(0, -32768, 255, 127, 1'b1);
    idle(2);
    mute_mask = 16'h0001;
    drive_slot(0, -32768, 255, 127, 1'b1);
    drain();
    mute_mask = '0;

    // T4: output stalled, two frames dropped
    out_ready = 1'b0;
    drive_slot(0, 100, 255, 127, 1'b1);
    idle(2);
    sb_enable = 1'b0;
    drive_slot(0, 200, 255, 127, 1'b1);
    idle(2);
    drive_slot(0, 300, 255, 127, 1'b1);
    idle(3);
    sb_enable = 1'b1;
    check("t4_held_sample", 32'(out_sample), 98);
    check("t4_drop_count", 32'(drop_count), 2);
    check("t4_held_valid", 32'(out_valid), 1);
    drive_slot(0, 400, 255, 127, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("t4_reload_valid", 32'(out_valid), 1);
    check("t4_reload_sample", 32'(out_sample), 394);
    check("t4_drop_after", 32'(drop_count), 2);
    drain();

    // T5: reset mid-frame
    drive_slot(1, 1000, 255, 127, 1'b0);
    drive_slot(2, 1000, 255, 127, 1'b0);
    in_valid = 1'b0;
    reset_n = 1'b0;
    acc_m = 0;
    @(posedge clock); #1;
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_sample", 32'(out_sample), 0);
    check("t5_drop_count", 32'(drop_count), 0);
    reset_n = 1'b1;
    idle(1);
    drive_slot(0, 1000, 255, 127, 1'b1);
    drain();

    // T6: three back-to-back 16-slot frames with random data and mutes
    mute_mask = 16'($urandom);
    pop_cyc.delete();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 16; c++) begin
        r = 16'($urandom);
        drive_slot(c, int'(r), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), c == 15);
      end
    end
    drain();
    check("t6_frames", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("t6_spacing0", pop_cyc[1] - pop_cyc[0], 16);
      check("t6_spacing1", pop_cyc[2] - pop_cyc[1], 16);
    end
    check("t6_drop_count", 32'(drop_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
